manchester_rx: RTL and testbench



---
 rtl/manchester_rx.sv | 156 +++++++++++++++
 tb/tb_manchester_rx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : manchester_rx                                              |
// | Brief   : Manchester line decoder; bit timing is recovered from the  |
// |           mid-bit edges, with framing and timing error detection.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module manchester_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_WIDTH   = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_in,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);
  localparam int BIT_W = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] c_win_lo    = CNT_W'(3 * CLKS_PER_BIT / 4);
  localparam logic [CNT_W-1:0] c_win_hi    = CNT_W'(5 * CLKS_PER_BIT / 4);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [BIT_W-1:0] c_word_bits = BIT_W'(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECEIVE   = 2'd1,
    S_WAIT_NEXT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    hist_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
  logic [WORD_WIDTH-1:0]   shift_q, shift_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    early_q, early_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic                    w_line;
  logic                    w_edge;
  logic                    w_rise;
  logic [CNT_W-1:0]        w_elapsed;
  logic                    w_early;
  logic                    w_timeout;

  assign w_line    = sync_q[SYNC_STAGES-1];
  assign w_edge    = w_line ^ hist_q;
  assign w_rise    = w_line & ~hist_q;
  // Clocks elapsed since the last accepted mid edge, including this one.
  assign w_elapsed = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;
  assign w_early   = (w_elapsed < c_win_lo);
  assign w_timeout = (w_elapsed > c_win_hi);

  always_comb begin
    state_d  = state_q;
    cnt_d    = w_elapsed;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    early_d  = early_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_rise) begin
          state_d  = S_RECEIVE;
          cnt_d    = '0;
          bitcnt_d = '0;
          early_d  = 1'b0;
        end
      end

      S_RECEIVE, S_WAIT_NEXT: begin
        if (state_q == S_RECEIVE && bitcnt_q == c_word_bits) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = S_WAIT_NEXT;
          early_d = early_q | w_edge;
        end else if (w_edge && w_early) begin
          // Only the bit-boundary edge may precede the next mid edge.
          if (early_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            early_d = 1'b1;
          end
        end else if (w_edge && !w_timeout) begin
          cnt_d   = '0;
          early_d = 1'b0;
          if (state_q == S_RECEIVE) begin
            shift_d  = {w_rise, shift_q[WORD_WIDTH-1:1]};
            bitcnt_d = bitcnt_q + 1'b1;
          end else if (w_rise) begin
            state_d  = S_RECEIVE;
            bitcnt_d = '0;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (w_timeout) begin
          // Silence after a complete word is a normal end of burst.
          err_d   = (state_q == S_RECEIVE);
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      early_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], line_in};
      hist_q   <= w_line;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      early_q  <= early_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_manchester_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_manchester_rx                                           |
// | Brief   : Scoreboard bench driving Manchester frames into the        |
// |           manchester_rx decoder.                                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_manchester_rx;

  localparam int T    = 16;
  localparam int WW   = 8;
  localparam int SYNC = 2;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          line_in = 1'b0;
  logic [WW-1:0] data;
  logic          valid;
  logic          err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  int            cyc       = 0;
  int            valid_cnt = 0;
  int            err_cnt   = 0;
  int            both_cnt  = 0;
  logic [WW-1:0] got_q[$];
  int            vcyc_q[$];
  int            ecyc_q[$];

  logic [WW-1:0] exp_q[$];
  int            rd_idx   = 0;
  int            last_mid = 0;

  manchester_rx #(
    .CLKS_PER_BIT(T),
    .WORD_WIDTH  (WW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .line_in(line_in),
    .data   (data),
    .valid  (valid),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      got_q.push_back(data);
      vcyc_q.push_back(cyc);
    end
    if (err === 1'b1) begin
      err_cnt++;
      ecyc_q.push_back(cyc);
    end
    if (valid === 1'b1 && err === 1'b1) both_cnt++;
  end

  // One Manchester bit: h1 clocks of ~b, then the mid edge, then h2 clocks of b.
  task automatic send_bit(input logic b, input int h1, input int h2);
    line_in = ~b;
    repeat (h1) @(negedge clk);
    line_in  = b;
    last_mid = cyc;
    repeat (h2) @(negedge clk);
  endtask

  // Start bit plus nbits data bits; mid-to-mid spacing alternates pa, pb.
  task automatic send_frame(input logic [WW-1:0] word, input int nbits,
                            input int pa, input int pb);
    int   h2p;
    int   p;
    int   h1;
    logic b;
    h2p = 0;
    for (int i = 0; i <= nbits; i++) begin
      p  = (i % 2 == 0) ? pa : pb;
      h1 = (i == 0) ? p / 2 : p - h2p;
      if (i == 0) b = 1'b1;
      else        b = word[i-1];
      send_bit(b, h1, p / 2);
      h2p = p / 2;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    line_in = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int v0, e0, lat;
    logic [WW-1:0] exp_w;
    v0 = valid_cnt; e0 = err_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, WW, T, T);
    line_in = 1'b0;
    repeat (20 - T / 2) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold got=%b want=1", busy); end
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop got=%b want=0", busy); end
    repeat (10) @(negedge clk);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL single_valid_count got=%0d want=1", valid_cnt - v0); end
    total++; if (err_cnt - e0 != 0)   begin bad++; $display("FAIL single_err_count got=%0d want=0", err_cnt - e0); end
    lat = (vcyc_q.size() > rd_idx) ? vcyc_q[rd_idx] - last_mid : -1;
    total++; if (lat != SYNC + 2) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, SYNC + 2); end
    while (rd_idx < got_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL single_extra_word got=%h want=none", got_q[rd_idx]);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_q[rd_idx] !== exp_w) begin bad++; $display("FAIL single_data got=%h want=%h", got_q[rd_idx], exp_w); end
      end
      rd_idx++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing_words got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int v0, e0, idx0, lows, gap;
    logic [WW-1:0] exp_w;
    v0 = valid_cnt; e0 = err_cnt; idx0 = vcyc_q.size(); lows = 0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    fork
      begin
        send_frame(8'h00, WW, T, T);
        send_frame(8'hFF, WW, T, T);
        send_frame(8'h3C, WW, T, T);
        line_in = 1'b0;
      end
      begin
        repeat (24) @(negedge clk);
        repeat (400) begin
          @(negedge clk);
          if (busy !== 1'b1) lows++;
        end
      end
    join
    repeat (40) @(negedge clk);
    total++; if (valid_cnt - v0 != 3) begin bad++; $display("FAIL b2b_valid_count got=%0d want=3", valid_cnt - v0); end
    total++; if (err_cnt - e0 != 0)   begin bad++; $display("FAIL b2b_err_count got=%0d want=0", err_cnt - e0); end
    total++; if (lows != 0)           begin bad++; $display("FAIL b2b_busy_low_cycles got=%0d want=0", lows); end
    for (int k = 0; k < 2; k++) begin
      gap = (vcyc_q.size() >= idx0 + k + 2) ? vcyc_q[idx0+k+1] - vcyc_q[idx0+k] : -1;
      total++; if (gap != 9 * T) begin bad++; $display("FAIL b2b_spacing_%0d got=%0d want=%0d", k, gap, 9 * T); end
    end
    while (rd_idx < got_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL b2b_extra_word got=%h want=none", got_q[rd_idx]);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_q[rd_idx] !== exp_w) begin bad++; $display("FAIL b2b_data got=%h want=%h", got_q[rd_idx], exp_w); end
      end
      rd_idx++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing_words got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_tolerance();
    int v0, e0;
    logic [WW-1:0] exp_w;
    v0 = valid_cnt; e0 = err_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, WW, 13, 19);
    line_in = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL tol_valid_count got=%0d want=1", valid_cnt - v0); end
    total++; if (err_cnt - e0 != 0)   begin bad++; $display("FAIL tol_err_count got=%0d want=0", err_cnt - e0); end
    while (rd_idx < got_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL tol_extra_word got=%h want=none", got_q[rd_idx]);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_q[rd_idx] !== exp_w) begin bad++; $display("FAIL tol_data got=%h want=%h", got_q[rd_idx], exp_w); end
      end
      rd_idx++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL tol_missing_words got=%0d want=0", exp_q.size()); end
    exp_q.delete();

    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h5A, WW, 21, 21);
    line_in = 1'b0;
    repeat (60) @(negedge clk);
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL tol_slow_valid got=%0d want=0", valid_cnt - v0); end
    total++; if (err_cnt - e0 < 1)    begin bad++; $display("FAIL tol_slow_err got=%0d want>=1", err_cnt - e0); end
    rd_idx = got_q.size();
  endtask

  task automatic test_truncated();
    int v0, e0, eidx, dly;
    logic [WW-1:0] exp_w;
    v0 = valid_cnt; e0 = err_cnt; eidx = ecyc_q.size();
    send_frame(8'h96, 4, T, T);
    line_in = 1'b0;
    repeat (60) @(negedge clk);
    total++; if (err_cnt - e0 != 1)   begin bad++; $display("FAIL trunc_err_count got=%0d want=1", err_cnt - e0); end
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL trunc_valid_count got=%0d want=0", valid_cnt - v0); end
    dly = (ecyc_q.size() > eidx) ? ecyc_q[eidx] - last_mid : -1;
    total++;
    if (dly < 5 * T / 4 || dly > 5 * T / 4 + SYNC + 3) begin
      bad++; $display("FAIL trunc_err_delay got=%0d want=%0d..%0d", dly, 5 * T / 4, 5 * T / 4 + SYNC + 3);
    end
    total++; if (data !== 8'h5A) begin bad++; $display("FAIL trunc_data_kept got=%h want=5a", data); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL trunc_idle got=%b want=0", busy); end

    v0 = valid_cnt; e0 = err_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, WW, T, T);
    line_in = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL trunc_next_valid got=%0d want=1", valid_cnt - v0); end
    total++; if (err_cnt - e0 != 0)   begin bad++; $display("FAIL trunc_next_err got=%0d want=0", err_cnt - e0); end
    while (rd_idx < got_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL trunc_extra_word got=%h want=none", got_q[rd_idx]);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_q[rd_idx] !== exp_w) begin bad++; $display("FAIL trunc_next_data got=%h want=%h", got_q[rd_idx], exp_w); end
      end
      rd_idx++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL trunc_missing_words got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bit(1'b1, T / 2, T / 2);
    send_bit(1'b0, T / 2, T / 2);
    line_in = 1'b1;
    repeat (T / 2) @(negedge clk);
    line_in = 1'b0;
    repeat (3) @(negedge clk);
    line_in = 1'b1;
    repeat (2) @(negedge clk);
    line_in = 1'b0;
    repeat (T / 2 - 5) @(negedge clk);
    for (int i = 2; i < WW; i++) send_bit(1'b0, T / 2, T / 2);
    line_in = 1'b0;
    repeat (60) @(negedge clk);
    total++; if (err_cnt - e0 < 1)    begin bad++; $display("FAIL glitch_err got=%0d want>=1", err_cnt - e0); end
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", valid_cnt - v0); end
    rd_idx = got_q.size();
  endtask

  task automatic test_bad_start();
    int v0, e0;
    logic [WW-1:0] exp_w;
    v0 = valid_cnt; e0 = err_cnt;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, WW, T, T);
    send_bit(1'b0, T / 2, T / 2);
    line_in = 1'b0;
    repeat (60) @(negedge clk);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL badstart_valid got=%0d want=1", valid_cnt - v0); end
    total++; if (err_cnt - e0 != 1)   begin bad++; $display("FAIL badstart_err got=%0d want=1", err_cnt - e0); end
    while (rd_idx < got_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL badstart_extra_word got=%h want=none", got_q[rd_idx]);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_q[rd_idx] !== exp_w) begin bad++; $display("FAIL badstart_data got=%h want=%h", got_q[rd_idx], exp_w); end
      end
      rd_idx++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL badstart_missing_words got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    logic [WW-1:0] exp_w;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hC3, 5, T, T);
    line_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    repeat (60) @(negedge clk);
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL rstmid_valid got=%0d want=0", valid_cnt - v0); end
    total++; if (err_cnt - e0 != 0)   begin bad++; $display("FAIL rstmid_err got=%0d want=0", err_cnt - e0); end

    v0 = valid_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, WW, T, T);
    line_in = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL rstmid_next_valid got=%0d want=1", valid_cnt - v0); end
    while (rd_idx < got_q.size()) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL rstmid_extra_word got=%h want=none", got_q[rd_idx]);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_q[rd_idx] !== exp_w) begin bad++; $display("FAIL rstmid_data got=%h want=%h", got_q[rd_idx], exp_w); end
      end
      rd_idx++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_missing_words got=%0d want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tolerance();
    test_truncated();
    test_glitch();
    test_bad_start();
    test_reset_mid();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL valid_err_overlap got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
